// File: rtl/ds2_pad_emu_if.sv
// ds2_pad_emu_if: DualShock2 pad link (ATT/CLK/CMD from host, DAT/ACK from pad).
interface ds2_pad_emu_if;
    logic ds2_att;
    logic ds2_clk;
    logic ds2_cmd;
    logic ds2_dat;
    logic ds2_ack;

    modport master (
        output ds2_att, ds2_clk, ds2_cmd,
        input  ds2_dat, ds2_ack
    );

    modport slave (
        input  ds2_att, ds2_clk, ds2_cmd,
        output ds2_dat, ds2_ack
    );
endinterface

// File: rtl/ds2_pad_emu.sv
// ds2_pad_emu: device-side DualShock2 responder with snapshot pad state.
// Config/analog switching (0x43/0x44) is enabled by defining DS2_EMU_CONFIG_EN.
module ds2_pad_emu #(
    parameter int ACK_DELAY      = 8,
    parameter int ACK_WIDTH      = 4,
    parameter int ANALOG_DEFAULT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    ds2_pad_emu_if.slave pad,
    input  logic [15:0] buttons,
    input  logic [7:0]  stick_rx,
    input  logic [7:0]  stick_ry,
    input  logic [7:0]  stick_lx,
    input  logic [7:0]  stick_ly,
    output logic        analog_mode,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_AWAIT, S_ACK, S_DONE, S_IGN
    } state_t;

    state_t state, state_n;

    logic [2:0]  att_q, clk_q;
    logic [1:0]  cmd_q;
    logic        att_fall, att_rise, clk_fall, clk_rise;
    logic [3:0]  byte_idx, last_idx;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg, rx_byte, cmd_t, cur_byte, cnt;
    logic [15:0] btn_s;
    logic [7:0]  rx_s, ry_s, lx_s, ly_s;
    logic        ana_f, cfg_f, cfg;
    logic        dat_q, dat_n, ack_q, ack_n, busy_q;
    logic        start, last_rise;

    // ATT sync resets low so a frame already running at reset release
    // produces no fall; only a fresh high-to-low transition starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att_q <= 3'b000;
            clk_q <= 3'b111;
            cmd_q <= 2'b11;
        end else begin
            att_q <= {att_q[1:0], pad.ds2_att};
            clk_q <= {clk_q[1:0], pad.ds2_clk};
            cmd_q <= {cmd_q[0], pad.ds2_cmd};
        end
    end

    assign att_fall  = att_q[2] & ~att_q[1];
    assign att_rise  = ~att_q[2] & att_q[1];
    assign clk_fall  = clk_q[2] & ~clk_q[1];
    assign clk_rise  = ~clk_q[2] & clk_q[1];
    assign rx_byte   = {cmd_q[1], shreg[7:1]};
    assign last_idx  = (ana_f | cfg_f) ? 4'd8 : 4'd4;
    assign last_rise = clk_rise && (bit_idx == 3'd7);

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            4'd0: cur_byte = 8'hFF;
            4'd1: cur_byte = cfg_f ? 8'hF3 : (ana_f ? 8'h73 : 8'h41);
            4'd2: cur_byte = 8'h5A;
            4'd3: cur_byte = (cmd_t == 8'h42) ? ~btn_s[7:0] : 8'h00;
            4'd4: cur_byte = (cmd_t == 8'h42) ? ~btn_s[15:8] : 8'h00;
            4'd5: cur_byte = (cmd_t == 8'h42) ? rx_s : 8'h00;
            4'd6: cur_byte = (cmd_t == 8'h42) ? ry_s : 8'h00;
            4'd7: cur_byte = (cmd_t == 8'h42) ? lx_s : 8'h00;
            4'd8: cur_byte = (cmd_t == 8'h42) ? ly_s : 8'h00;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n = state;
        dat_n   = dat_q;
        ack_n   = ack_q;
        if (att_rise) begin
            state_n = S_IDLE;
            dat_n   = 1'b1;
            ack_n   = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    dat_n = 1'b1;
                    ack_n = 1'b1;
                    if (att_fall) state_n = S_SHIFT;
                end
                S_SHIFT: begin
                    if (last_rise) begin
                        dat_n = 1'b1;
                        if (byte_idx == 4'd0 && rx_byte != 8'h01)
                            state_n = S_IGN;
                        else if (byte_idx == last_idx)
                            state_n = S_DONE;
                        else
                            state_n = S_AWAIT;
                    end else if (clk_fall) begin
                        dat_n = cur_byte[bit_idx];
                    end
                end
                S_AWAIT: begin
                    if (cnt == 8'(ACK_DELAY - 1)) begin
                        state_n = S_ACK;
                        ack_n   = 1'b0;
                    end
                end
                S_ACK: begin
                    if (cnt == 8'(ACK_WIDTH - 1)) begin
                        state_n = S_SHIFT;
                        ack_n   = 1'b1;
                    end
                end
                default: begin
                    dat_n = 1'b1;
                    ack_n = 1'b1;
                end
            endcase
        end
    end

    assign start = (state == S_IDLE) && (state_n == S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dat_q    <= 1'b1;
            ack_q    <= 1'b1;
            busy_q   <= 1'b0;
            byte_idx <= 4'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
            cmd_t    <= 8'h00;
            cnt      <= 8'h00;
            btn_s    <= 16'h0000;
            rx_s     <= 8'h00;
            ry_s     <= 8'h00;
            lx_s     <= 8'h00;
            ly_s     <= 8'h00;
            ana_f    <= 1'b0;
            cfg_f    <= 1'b0;
        end else begin
            state <= state_n;
            dat_q <= dat_n;
            ack_q <= ack_n;
            if (att_fall)      busy_q <= 1'b1;
            else if (att_rise) busy_q <= 1'b0;
            cnt <= (state_n != state) ? 8'h00 : cnt + 8'h01;
            if (start) begin
                btn_s    <= buttons;
                rx_s     <= stick_rx;
                ry_s     <= stick_ry;
                lx_s     <= stick_lx;
                ly_s     <= stick_ly;
                ana_f    <= analog_mode;
                cfg_f    <= cfg;
                byte_idx <= 4'd0;
                bit_idx  <= 3'd0;
            end
            if (state == S_SHIFT && clk_rise && !att_rise) begin
                shreg   <= rx_byte;
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7 && byte_idx == 4'd1) cmd_t <= rx_byte;
            end
            if (state == S_ACK && state_n == S_SHIFT)
                byte_idx <= byte_idx + 4'd1;
        end
    end

`ifdef DS2_EMU_CONFIG_EN
    logic [7:0] b3;
    logic       b3_ok;

    // Byte 3 must arrive complete; the mode only changes at ATT rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg         <= 1'b0;
            analog_mode <= 1'(ANALOG_DEFAULT);
            b3          <= 8'h00;
            b3_ok       <= 1'b0;
        end else begin
            if (start) begin
                b3_ok <= 1'b0;
            end else if (state == S_SHIFT && last_rise && !att_rise
                         && byte_idx == 4'd3) begin
                b3    <= rx_byte;
                b3_ok <= 1'b1;
            end
            if (att_rise && b3_ok) begin
                b3_ok <= 1'b0;
                if (cmd_t == 8'h43) begin
                    if (b3 == 8'h01)      cfg <= 1'b1;
                    else if (b3 == 8'h00) cfg <= 1'b0;
                end
                if (cmd_t == 8'h44 && cfg_f) begin
                    if (b3 == 8'h01)      analog_mode <= 1'b1;
                    else if (b3 == 8'h00) analog_mode <= 1'b0;
                end
            end
        end
    end
`else
    assign cfg         = 1'b0;
    assign analog_mode = 1'(ANALOG_DEFAULT);
`endif

    assign pad.ds2_dat = dat_q;
    assign pad.ds2_ack = ack_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ds2_pad_emu.sv
// tb_ds2_pad_emu: host-side bench driving a digital-default and an
// analog-default emulator in lockstep over the same pad link.
module tb_ds2_pad_emu;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        hatt = 1'b1, hclk = 1'b1, hcmd = 1'b1;
    logic [15:0] buttons;
    logic [7:0]  rx, ry, lx, ly;
    logic        md, ma, bd, ba;

    ds2_pad_emu_if pd();
    ds2_pad_emu_if pa();

    assign pd.ds2_att = hatt;
    assign pd.ds2_clk = hclk;
    assign pd.ds2_cmd = hcmd;
    assign pa.ds2_att = hatt;
    assign pa.ds2_clk = hclk;
    assign pa.ds2_cmd = hcmd;

    ds2_pad_emu #(.ANALOG_DEFAULT(0)) u_d (
        .clk(clk), .rst_n(rst_n), .pad(pd), .buttons(buttons),
        .stick_rx(rx), .stick_ry(ry), .stick_lx(lx), .stick_ly(ly),
        .analog_mode(md), .busy(bd)
    );

    ds2_pad_emu #(.ANALOG_DEFAULT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .pad(pa), .buttons(buttons),
        .stick_rx(rx), .stick_ry(ry), .stick_lx(lx), .stick_ly(ly),
        .analog_mode(ma), .busy(ba)
    );

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dd;
        logic [7:0] da;
        logic       kd;
        logic       ka;
    } vec_t;

    typedef logic [7:0] b9_t [9];

    vec_t sbq[$];

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] c, output logic [7:0] rd, output logic [7:0] ra);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            hclk = 1'b0;
            hcmd = c[b];
            repeat (8) @(negedge clk);
            rd[b] = pd.ds2_dat;
            ra[b] = pa.ds2_dat;
            hclk = 1'b1;
            if (b < 7) repeat (7) @(negedge clk);
        end
    endtask

    task automatic xfer(input logic [7:0] c, output logic [7:0] rd, output logic [7:0] ra,
                        output logic kd, output logic ka);
        send_bits(c, rd, ra);
        kd = 1'b0;
        ka = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (!pd.ds2_ack) kd = 1'b1;
            if (!pa.ds2_ack) ka = 1'b1;
        end
    endtask

    task automatic run_frame(input string nm, input b9_t c, input b9_t d, input b9_t a,
                             input logic [8:0] kd, input logic [8:0] ka);
        vec_t tbl[9];
        vec_t e;
        logic [7:0] rd, ra;
        logic gk, gka;
        for (int i = 0; i < 9; i++)
            tbl[i] = '{cmd: c[i], dd: d[i], da: a[i], kd: kd[i], ka: ka[i]};
        @(negedge clk);
        hatt = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            sbq.push_back(tbl[i]);
            xfer(tbl[i].cmd, rd, ra, gk, gka);
            e = sbq.pop_front();
            chk8($sformatf("%s b%0d dat_d", nm, i), rd, e.dd);
            chk8($sformatf("%s b%0d dat_a", nm, i), ra, e.da);
            chk1($sformatf("%s b%0d ack_d", nm, i), gk, e.kd);
            chk1($sformatf("%s b%0d ack_a", nm, i), gka, e.ka);
        end
        chk1({nm, " busy_d"}, bd, 1'b1);
        chk1({nm, " busy_a"}, ba, 1'b1);
        hatt = 1'b1;
        repeat (8) @(negedge clk);
        chk1({nm, " busy_d end"}, bd, 1'b0);
        chk1({nm, " busy_a end"}, ba, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        b9_t vc, vd, va;
        logic [7:0] rd, ra;
        logic gk, gka;
        int w;

        rst_n   = 1'b0;
        buttons = 16'h0001;
        rx = 8'h80; ry = 8'h7F; lx = 8'h00; ly = 8'hFF;
        repeat (3) @(negedge clk);
        chk1("rst dat_d", pd.ds2_dat, 1'b1);
        chk1("rst ack_d", pd.ds2_ack, 1'b1);
        chk1("rst busy_d", bd, 1'b0);
        chk1("rst mode_d", md, 1'b0);
        chk1("rst mode_a", ma, 1'b1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        vc = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vd = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        va = '{8'hFF, 8'h73, 8'h5A, 8'hFE, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'hFF};
        run_frame("pollA", vc, vd, va, 9'h00F, 9'h0FF);

        buttons = 16'h0000;
        vd = '{8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        va = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h00, 8'hFF};
        run_frame("pollB", vc, vd, va, 9'h00F, 9'h0FF);

        vc = '{8'h81, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vd = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_frame("hdr81", vc, vd, vd, 9'h000, 9'h000);
        chk1("hdr81 mode_d", md, 1'b0);
        chk1("hdr81 mode_a", ma, 1'b1);

        vc = '{8'h01, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vd = '{8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        va = '{8'hFF, 8'h73, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("cmd45", vc, vd, va, 9'h00F, 9'h0FF);

        // abort a 0x44 frame after four bits of byte 3
        @(negedge clk);
        hatt = 1'b0;
        repeat (10) @(negedge clk);
        xfer(8'h01, rd, ra, gk, gka);
        chk8("abort b0 dat_d", rd, 8'hFF);
        chk1("abort b0 ack_a", gka, 1'b1);
        xfer(8'h44, rd, ra, gk, gka);
        chk8("abort b1 dat_d", rd, 8'h41);
        chk8("abort b1 dat_a", ra, 8'h73);
        xfer(8'h00, rd, ra, gk, gka);
        chk8("abort b2 dat_a", ra, 8'h5A);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            hclk = 1'b0;
            hcmd = (b == 0);
            repeat (8) @(negedge clk);
            hclk = 1'b1;
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        hclk = 1'b0;
        hcmd = 1'b0;
        repeat (8) @(negedge clk);
        chk1("abort pre dat_d", pd.ds2_dat, 1'b0);
        chk1("abort pre dat_a", pa.ds2_dat, 1'b0);
        hatt = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk1("abort dat_d", pd.ds2_dat, 1'b1);
        chk1("abort dat_a", pa.ds2_dat, 1'b1);
        chk1("abort ack_a", pa.ds2_ack, 1'b1);
        @(negedge clk);
        hclk = 1'b1;
        repeat (10) @(negedge clk);
        chk1("abort mode_d", md, 1'b0);
        chk1("abort mode_a", ma, 1'b1);

        buttons = 16'h8421;
        vc = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vd = '{8'hFF, 8'h41, 8'h5A, 8'hDE, 8'h7B, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        va = '{8'hFF, 8'h73, 8'h5A, 8'hDE, 8'h7B, 8'h80, 8'h7F, 8'h00, 8'hFF};
        run_frame("postabort", vc, vd, va, 9'h00F, 9'h0FF);

        // reset pulse during the byte 1 acknowledge
        @(negedge clk);
        hatt = 1'b0;
        repeat (10) @(negedge clk);
        xfer(8'h01, rd, ra, gk, gka);
        chk1("rstmid b0 ack_d", gk, 1'b1);
        send_bits(8'h42, rd, ra);
        chk8("rstmid b1 dat_a", ra, 8'h73);
        w = 0;
        while (pd.ds2_ack && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk1("rstmid ack seen", w < 30, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rstmid ack_d", pd.ds2_ack, 1'b1);
        chk1("rstmid ack_a", pa.ds2_ack, 1'b1);
        chk1("rstmid dat_d", pd.ds2_dat, 1'b1);
        chk1("rstmid mode_d", md, 1'b0);
        chk1("rstmid mode_a", ma, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, rd, ra, gk, gka);
            chk8($sformatf("rstmid q%0d dat_d", i), rd, 8'hFF);
            chk8($sformatf("rstmid q%0d dat_a", i), ra, 8'hFF);
            chk1($sformatf("rstmid q%0d ack_d", i), gk, 1'b0);
            chk1($sformatf("rstmid q%0d ack_a", i), gka, 1'b0);
        end
        chk1("rstmid busy_a", ba, 1'b0);
        hatt = 1'b1;
        repeat (8) @(negedge clk);
        run_frame("postrst", vc, vd, va, 9'h00F, 9'h0FF);

`ifdef DS2_EMU_CONFIG_EN
        vc = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vd = '{8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        va = '{8'hFF, 8'h73, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("cfg_in", vc, vd, va, 9'h00F, 9'h0FF);
        chk1("cfg_in mode_d", md, 1'b0);

        vc = '{8'h01, 8'h44, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vd = '{8'hFF, 8'hF3, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("cfg_ana", vc, vd, vd, 9'h0FF, 9'h0FF);
        chk1("cfg_ana mode_d", md, 1'b1);
        chk1("cfg_ana mode_a", ma, 1'b1);

        vc = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("cfg_out", vc, vd, vd, 9'h0FF, 9'h0FF);
        chk1("cfg_out mode_d", md, 1'b1);

        vc = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        va = '{8'hFF, 8'h73, 8'h5A, 8'hDE, 8'h7B, 8'h80, 8'h7F, 8'h00, 8'hFF};
        run_frame("cfg_poll", vc, va, va, 9'h0FF, 9'h0FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
